fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, drives the

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, the IF/ID register and EPC.
// Redirects come from DECODE and are applied with a single flush bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        stop,
  input  logic        JBEQ,
  input  logic        J,
  input  logic        JAL,
  input  logic        JR,
  input  logic        RFE,
  input  logic        wrongInst,
  input  logic [31:0] jr_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D,
  output logic [31:0] epc,
  output logic        exc_taken
);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic [31:0] r_epc;
  logic        r_exc;

  logic [31:0] w_pc4;
  logic [31:0] w_br;
  logic [31:0] w_jmp;
  logic        w_go;
  logic        w_exc;
  logic        w_rfe;
  logic        w_jr;
  logic        w_jmp_sel;
  logic        w_br_sel;
  logic        w_seq;

  logic [31:0] w_pc_f_n;
  logic [31:0] w_instr_n;
  logic [31:0] w_pc_d_n;
  logic        w_valid_n;
  logic [31:0] w_epc_n;
  logic        w_exc_n;

  assign w_pc4 = r_pc_d + 32'd4;
  assign w_br  = w_pc4
               + {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};
  assign w_jmp = {w_pc4[31:28], r_instr_d[25:0], 2'b00};

  // One-hot selects; flags only count when IF/ID holds a real fetch
  assign w_go      = ~stop & ~stall;
  assign w_exc     = w_go & r_valid_d & wrongInst;
  assign w_rfe     = w_go & r_valid_d & ~wrongInst & RFE;
  assign w_jr      = w_go & r_valid_d & ~wrongInst & ~RFE & JR;
  assign w_jmp_sel = w_go & r_valid_d & ~wrongInst & ~RFE & ~JR
                   & (J | JAL);
  assign w_br_sel  = w_go & r_valid_d & ~wrongInst & ~RFE & ~JR
                   & ~J & ~JAL & JBEQ;
  assign w_seq     = w_go & ~w_exc & ~w_rfe & ~w_jr
                   & ~w_jmp_sel & ~w_br_sel;

  always_comb begin
    w_pc_f_n  = r_pc_f;
    w_instr_n = r_instr_d;
    w_pc_d_n  = r_pc_d;
    w_valid_n = r_valid_d;
    w_epc_n   = r_epc;
    w_exc_n   = 1'b0;
    if (w_exc | w_rfe | w_jr | w_jmp_sel | w_br_sel) begin
      w_instr_n = NOP_INSTR;
      w_pc_d_n  = 32'd0;
      w_valid_n = 1'b0;
    end
    unique case (1'b1)
      w_exc: begin
        w_epc_n  = r_pc_d;
        w_pc_f_n = EXC_VECTOR;
        w_exc_n  = 1'b1;
      end
      w_rfe:     w_pc_f_n = r_epc;
      w_jr:      w_pc_f_n = jr_target;
      w_jmp_sel: w_pc_f_n = w_jmp;
      w_br_sel:  w_pc_f_n = w_br;
      w_seq: begin
        w_pc_f_n  = r_pc_f + 32'd4;
        w_instr_n = imem_rdata;
        w_pc_d_n  = r_pc_f;
        w_valid_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc_f    <= RESET_PC;
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'd0;
      r_valid_d <= 1'b0;
      r_epc     <= 32'd0;
      r_exc     <= 1'b0;
    end else begin
      r_pc_f    <= w_pc_f_n;
      r_instr_d <= w_instr_n;
      r_pc_d    <= w_pc_d_n;
      r_valid_d <= w_valid_n;
      r_epc     <= w_epc_n;
      r_exc     <= w_exc_n;
    end
  end

  assign imem_addr = r_pc_f;
  assign instr_D   = r_instr_d;
  assign pc_D      = r_pc_d;
  assign pc4_D     = w_pc4;
  assign valid_D   = r_valid_d;
  assign epc       = r_epc;
  assign exc_taken = r_exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed redirect scenarios, then random
// flag/stall/stop traffic against a priority-rule reference model.
module tb_fetch_stage;

  localparam logic [31:0] EXC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 0, stop = 0;
  logic        JBEQ = 0, J = 0, JAL = 0, JR = 0, RFE = 0, wrongInst = 0;
  logic [31:0] jr_target = 0;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, instr_D, pc_D, pc4_D, epc;
  logic        valid_D, exc_taken;

  logic [31:0] mem [64];
  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] m_pc = 0, m_instr = 0, m_pcd = 0, m_epc = 0;
  logic        m_valid = 0, m_exc = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[7:2]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .stop(stop),
    .JBEQ(JBEQ), .J(J), .JAL(JAL), .JR(JR), .RFE(RFE),
    .wrongInst(wrongInst), .jr_target(jr_target),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .instr_D(instr_D), .pc_D(pc_D), .pc4_D(pc4_D),
    .valid_D(valid_D), .epc(epc), .exc_taken(exc_taken)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the redirect priority list applied to architectural values
  always @(posedge clk or negedge rst) begin
    logic [31:0] ret, tgt;
    if (!rst) begin
      m_pc = 0; m_instr = 0; m_pcd = 0;
      m_valid = 0; m_epc = 0; m_exc = 0;
    end else begin
      m_exc = 0;
      ret = m_pcd + 4;
      tgt = m_pc + 4;
      if (stop || stall) begin
      end else if (m_valid && (wrongInst || RFE || JR || J || JAL || JBEQ)) begin
        if (wrongInst) begin
          m_epc = m_pcd; tgt = EXC; m_exc = 1;
        end else if (RFE) tgt = m_epc;
        else if (JR) tgt = jr_target;
        else if (J || JAL)
          tgt = (ret & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        else
          tgt = ret + 32'(4 * int'($signed(m_instr[15:0])));
        m_pc = tgt; m_instr = 0; m_pcd = 0; m_valid = 0;
      end else begin
        m_instr = mem[m_pc[7:2]];
        m_pcd = m_pc;
        m_valid = 1;
        m_pc = tgt;
      end
    end
  end

  task automatic cmp_model();
    check("m_pcF", imem_addr, m_pc);
    check("m_instrD", instr_D, m_instr);
    check("m_pcD", pc_D, m_pcd);
    check("m_pc4D", pc4_D, m_pcd + 32'd4);
    check("m_validD", 32'(valid_D), 32'(m_valid));
    check("m_epc", epc, m_epc);
    check("m_exc", 32'(exc_taken), 32'(m_exc));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic clr();
    stall = 0; stop = 0; JBEQ = 0; J = 0; JAL = 0;
    JR = 0; RFE = 0; wrongInst = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[2] = {6'h03, 26'h40};
    mem[4] = 32'h1000_FFFE;

    @(negedge clk);
    check("rst_pcF", imem_addr, 32'h0);
    check("rst_valid", 32'(valid_D), 32'h0);
    check("rst_instr", instr_D, 32'h0);
    rst = 1;
    tick(); check("i0", instr_D, mem[0]);
    check("i0_v", 32'(valid_D), 32'h1);
    tick(); check("i1", instr_D, mem[1]);
    tick(); check("i2", instr_D, mem[2]);
    tick(); tick();
    check("beq_pcD", pc_D, 32'h10);
    JBEQ = 1; tick(); JBEQ = 0;
    check("beq_pcF", imem_addr, 32'h0C);
    check("beq_bubble", 32'(valid_D), 32'h0);
    tick();
    JR = 1; jr_target = 32'h1000_0008; tick(); JR = 0;
    tick();
    check("jal_pcD", pc_D, 32'h1000_0008);
    check("jal_pc4", pc4_D, 32'h1000_000C);
    JAL = 1; tick(); JAL = 0;
    check("jal_pcF", imem_addr, 32'h1000_0100);
    tick();
    JR = 1; jr_target = 32'h24; tick(); JR = 0;
    tick();
    wrongInst = 1; tick(); wrongInst = 0;
    check("exc_epc", epc, 32'h24);
    check("exc_pcF", imem_addr, EXC);
    check("exc_pulse", 32'(exc_taken), 32'h1);
    tick();
    check("exc_drop", 32'(exc_taken), 32'h0);
    RFE = 1; tick(); RFE = 0;
    check("rfe_pcF", imem_addr, 32'h24);
    tick();
    JR = 1; jr_target = 32'h40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_pcF", imem_addr, 32'h28);
      check("stl_pcD", pc_D, 32'h24);
    end
    stall = 0; tick(); JR = 0;
    check("jr_pcF", imem_addr, 32'h40);
    tick();
    stop = 1; stall = 1; wrongInst = 1; tick(); clr();
    check("stop_pcF", imem_addr, 32'h44);
    check("stop_pcD", pc_D, 32'h40);
    check("stop_epc", epc, 32'h24);
    check("stop_exc", 32'(exc_taken), 32'h0);
    JBEQ = 1; #2 rst = 0; #1;
    check("arst_pcF", imem_addr, 32'h0);
    check("arst_valid", 32'(valid_D), 32'h0);
    check("arst_epc", epc, 32'h0);
    tick(); clr(); rst = 1;
    tick();

    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 99) < 20);
      stop = ($urandom_range(0, 99) < 8);
      wrongInst = ($urandom_range(0, 99) < 8);
      RFE = ($urandom_range(0, 99) < 10);
      JR = ($urandom_range(0, 99) < 12);
      J = ($urandom_range(0, 99) < 10);
      JAL = ($urandom_range(0, 99) < 10);
      JBEQ = ($urandom_range(0, 99) < 15);
      jr_target = $urandom;
      if ($urandom_range(0, 99) < 2) begin
        #1 rst = 0; #1;
        cmp_model();
        rst = 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
